// File: rtl/spi_audio_rx_pkg.sv
// Shared audio-path definitions: default word width, default FIFO depth
// and the state type of the SPI receive FSM.
package spi_audio_rx_pkg;

   localparam int AUDIO_WORD_W     = 32;
   localparam int AUDIO_FIFO_DEPTH = 256;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_rx_state_t;

endpackage

// File: rtl/spi_audio_rx_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with a registered
// head. The level counter is one bit wider than the pointers, so full and
// empty can be told apart. A push into a full FIFO is refused and reported
// on 'drop', unless a pop happens in the same cycle. A pop frees the slot
// that the push then fills.
module sync_fifo
   import spi_audio_rx_pkg::*;
#(
   parameter int WIDTH = AUDIO_WORD_W,
   parameter int DEPTH = AUDIO_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       drop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_n;
   logic [LW-1:0]    remain;
   logic [LW-1:0]    level_n;
   logic [WIDTH-1:0] head_n;
   logic             pop_ok;
   logic             push_ok;
   logic             full;

   // Decide this cycle's push/pop. Compute the next head so that the output
   // register always shows the oldest entry one cycle after it changes.
   always_comb begin
      pop_ok   = rd_valid & rd_ready;
      full     = (level == LW'(DEPTH));
      push_ok  = wr_en & (~full | pop_ok);
      drop     = wr_en & ~push_ok;
      rd_ptr_n = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
      remain   = level - {{AW{1'b0}}, pop_ok};
      level_n  = remain + {{AW{1'b0}}, push_ok};
      head_n   = (remain == '0) ? wr_data : mem[rd_ptr_n];
   end

   // Storage array. It is not reset, because the level decides what is live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the registered head-of-queue output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr   <= rd_ptr_n;
         level    <= level_n;
         rd_valid <= (level_n != '0);
         if (level_n != '0) begin
            rd_data <= head_n;
         end
      end
   end

endmodule

// File: rtl/spi_audio_rx.sv
// spi_audio_rx: SPI mode-0 slave that receives PCM words MSB first. It
// brings them into the clk domain and queues them for the I2S side through
// a valid/ready stream.
// Optional build macro SPI_AUDIO_RX_STATUS_EN adds status readback on
// spi_miso: {overflow, fifo_level}, sampled at each word start and sent
// MSB first. Without the macro, spi_miso is tied low.
module spi_audio_rx
   import spi_audio_rx_pkg::*;
#(
   parameter int WORD_W      = AUDIO_WORD_W,
   parameter int FIFO_DEPTH  = AUDIO_FIFO_DEPTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          spi_sclk,
   input  logic                          spi_cs_n,
   input  logic                          spi_mosi,
   output logic                          spi_miso,
   output logic [WORD_W-1:0]             m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic                          frame_err
);

   localparam int             CW       = $clog2(WORD_W);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WORD_W - 1);

   logic [SYNC_STAGES-1:0] sclk_ff;
   logic [SYNC_STAGES-1:0] cs_ff;
   logic [SYNC_STAGES-1:0] mosi_ff;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_d;
   logic                   sclk_rise;

   spi_rx_state_t          state;
   spi_rx_state_t          state_n;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_n;
   logic [WORD_W-1:0]      shreg;
   logic [WORD_W-1:0]      shreg_n;
   logic                   word_done;
   logic                   ferr_n;
   logic                   push_q;
   logic                   fifo_drop;

   // Synchronise the three SPI inputs. Chip select resets to its inactive
   // (high) level so that reset never looks like the start of a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_ff <= '0;
         cs_ff   <= '1;
         mosi_ff <= '0;
         sclk_d  <= 1'b0;
      end else begin
         sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], spi_sclk};
         cs_ff   <= {cs_ff[SYNC_STAGES-2:0], spi_cs_n};
         mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], spi_mosi};
         sclk_d  <= sclk_s;
      end
   end

   assign sclk_s    = sclk_ff[SYNC_STAGES-1];
   assign cs_s      = cs_ff[SYNC_STAGES-1];
   assign mosi_s    = mosi_ff[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;

   // Receive FSM. Collect bits on SCLK rising edges and flag each completed
   // word. A frame that ends part-way through a word is dropped and flagged.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      shreg_n   = shreg;
      word_done = 1'b0;
      ferr_n    = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!cs_s) begin
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_s) begin
               state_n = IDLE;
               cnt_n   = '0;
               ferr_n  = (cnt != '0);
            end else if (sclk_rise) begin
               shreg_n = {shreg[WORD_W-2:0], mosi_s};
               if (cnt == LAST_BIT) begin
                  cnt_n     = '0;
                  word_done = 1'b1;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // FSM state, bit counter and shift register. Also register the push
   // request and the frame-error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         push_q    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         shreg     <= shreg_n;
         push_q    <= word_done;
         frame_err <= ferr_n;
      end
   end

   // Sticky overflow flag. A new drop takes priority over a clear in the
   // same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (fifo_drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   // The shift register stays stable for the push cycle, because the next
   // SCLK rise is several clk cycles away.
   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (push_q),
      .wr_data  (shreg),
      .drop     (fifo_drop),
      .rd_data  (m_data),
      .rd_valid (m_valid),
      .rd_ready (m_ready),
      .level    (fifo_level)
   );

`ifdef SPI_AUDIO_RX_STATUS_EN
   logic              sclk_fall;
   logic [WORD_W-1:0] snap;
   logic [WORD_W-1:0] tx_sr;

   assign sclk_fall = ~sclk_s & sclk_d;
   assign snap      = WORD_W'({overflow, fifo_level});

   // Status readback. Drive the MSB as soon as the frame opens. At later
   // word boundaries, reload the snapshot so that the next SCLK fall sends
   // its MSB. Between those points, shift one bit out per SCLK fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_miso <= 1'b0;
         tx_sr    <= '0;
      end else if (cs_s) begin
         spi_miso <= 1'b0;
      end else if (state == IDLE) begin
         spi_miso <= snap[WORD_W-1];
         tx_sr    <= snap << 1;
      end else if (word_done) begin
         tx_sr    <= snap;
      end else if (sclk_fall) begin
         spi_miso <= tx_sr[WORD_W-1];
         tx_sr    <= tx_sr << 1;
      end
   end
`else
   assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_audio_rx.sv
// Testbench for spi_audio_rx. An SPI master bit-bangs directed words. A
// queue model of the FIFO, with the overflow flag, is compared every cycle
// against level, valid, head data and overflow. Literal checks pin the
// model on the key scenarios.
module tb_spi_audio_rx;

   localparam int DEPTH = 256;
   localparam int HALF  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_sclk;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [8:0]  fifo_level;
   logic        overflow;
   logic        clr_overflow;
   logic        frame_err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] popped_q[$];
   logic        ovf_model = 1'b0;
   int          peak = 0;
   int          ferr_cnt = 0;

   always #5 clk = ~clk;

   spi_audio_rx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_sclk     (spi_sclk),
      .spi_cs_n     (spi_cs_n),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .frame_err    (frame_err)
   );

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of a word arriving at the FIFO: queue it, or drop it when full.
   function automatic void model_push(input logic [31:0] w);
      if (exp_q.size() >= DEPTH) ovf_model = 1'b1;
      else exp_q.push_back(w);
   endfunction

   // Compare DUT against model once per cycle, clear of the clock edges.
   initial forever begin
      @(negedge clk);
      #1;
      check_output("level", 64'(fifo_level), 64'(exp_q.size()));
      check_output("valid", 64'(m_valid), 64'(exp_q.size() != 0));
      check_output("overflow", 64'(overflow), 64'(ovf_model));
      if (m_valid && exp_q.size() != 0) check_output("data", 64'(m_data), 64'(exp_q[0]));
      if (frame_err) ferr_cnt++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (m_valid && m_ready && exp_q.size() != 0) begin
         popped_q.push_back(m_data);
         void'(exp_q.pop_front());
      end
   end

   task automatic start_frame();
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic end_frame();
      spi_sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (3 * HALF) @(negedge clk);
   endtask

   // One full word, MSB first. The model takes the word 4 clk cycles after
   // the last raw SCLK rise. 'pulse' raises m_ready for exactly that cycle.
   task automatic apply_stimulus(input logic [31:0] w, input bit pulse, output logic [31:0] miso_word);
      miso_word = '0;
      for (int i = 31; i >= 0; i--) begin
         spi_sclk = 1'b0;
         spi_mosi = w[i];
         repeat (HALF) @(negedge clk);
         miso_word[i] = spi_miso;
         spi_sclk = 1'b1;
         if (i > 0) begin
            repeat (HALF) @(negedge clk);
         end else begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            if (pulse) m_ready = 1'b1;
            @(posedge clk);
            #1 model_push(w);
            @(negedge clk);
            if (pulse) m_ready = 1'b0;
         end
      end
   endtask

   task automatic send_partial(input logic [31:0] w, input int n);
      for (int i = 31; i > 31 - n; i--) begin
         spi_sclk = 1'b0;
         spi_mosi = w[i];
         repeat (HALF) @(negedge clk);
         spi_sclk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic drain(input int limit);
      m_ready = 1'b1;
      for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
      check_output("drain_done", 64'(exp_q.size()), 64'd0);
      m_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      check_output({tag, "_m_data"}, 64'(m_data), 64'd0);
      check_output({tag, "_level"}, 64'(fifo_level), 64'd0);
      check_output({tag, "_overflow"}, 64'(overflow), 64'd0);
      check_output({tag, "_frame_err"}, 64'(frame_err), 64'd0);
      check_output({tag, "_miso"}, 64'(spi_miso), 64'd0);
   endtask

   initial begin
      logic [31:0] mw;
      logic [31:0] exp_snap;
      int          mark;

      rst_n        = 1'b0;
      spi_sclk     = 1'b0;
      spi_cs_n     = 1'b1;
      spi_mosi     = 1'b0;
      m_ready      = 1'b0;
      clr_overflow = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] back-to-back words in one frame");
      peak    = 0;
      m_ready = 1'b1;
      start_frame();
      apply_stimulus(32'hDEADBEEF, 1'b0, mw);
      apply_stimulus(32'h12345678, 1'b0, mw);
      end_frame();
      check_output("b2b_count", 64'(popped_q.size()), 64'd2);
      if (popped_q.size() >= 2) begin
         check_output("b2b_first", 64'(popped_q[0]), 64'hDEADBEEF);
         check_output("b2b_second", 64'(popped_q[1]), 64'h12345678);
      end
      check_output("b2b_peak", 64'(peak), 64'd1);
      check_output("b2b_ferr", 64'(ferr_cnt), 64'd0);

      $display("[TB] aborted word then full word");
      start_frame();
      send_partial(32'h13579BDF, 17);
      end_frame();
      check_output("abort_ferr", 64'(ferr_cnt), 64'd1);
      start_frame();
      apply_stimulus(32'hA5A5A5A5, 1'b0, mw);
      end_frame();
      check_output("abort_count", 64'(popped_q.size()), 64'd3);
      if (popped_q.size() >= 3) check_output("abort_word", 64'(popped_q[2]), 64'hA5A5A5A5);
      check_output("abort_ferr_after", 64'(ferr_cnt), 64'd1);

      $display("[TB] status readback with five words stored");
      m_ready = 1'b0;
      start_frame();
      for (int i = 0; i < 5; i++) apply_stimulus(32'h5000_0000 + 32'(i), 1'b0, mw);
      end_frame();
      check_output("status_level", 64'(fifo_level), 64'd5);
      exp_snap = (ovf_model ? 32'h200 : 32'h0) + 32'(exp_q.size());
      start_frame();
      apply_stimulus(32'h0F0F0F0F, 1'b0, mw);
      end_frame();
`ifdef SPI_AUDIO_RX_STATUS_EN
      check_output("status_miso_model", 64'(mw), 64'(exp_snap));
      check_output("status_miso_literal", 64'(mw), 64'h00000005);
`else
      check_output("status_miso_off", 64'(mw), 64'd0);
`endif
      drain(40);

      $display("[TB] overflow with 257 words");
      m_ready = 1'b0;
      start_frame();
      for (int i = 1; i <= 257; i++) apply_stimulus(32'hC000_0000 + 32'(i), 1'b0, mw);
      end_frame();
      check_output("ovf_level", 64'(fifo_level), 64'd256);
      check_output("ovf_flag", 64'(overflow), 64'd1);

      $display("[TB] push and pop together while full");
      mark = popped_q.size();
      start_frame();
      apply_stimulus(32'h0BADF00D, 1'b1, mw);
      end_frame();
      check_output("full_pp_level", 64'(fifo_level), 64'd256);
      check_output("full_pp_popcnt", 64'(popped_q.size() - mark), 64'd1);
      if (popped_q.size() > mark) check_output("full_pp_oldest", 64'(popped_q[mark]), 64'hC0000001);
      drain(400);
      check_output("full_pp_drained", 64'(popped_q.size() - mark), 64'd257);
      if (popped_q.size() == mark + 257) begin
         check_output("drain_first", 64'(popped_q[mark + 1]), 64'hC0000002);
         check_output("drain_256", 64'(popped_q[mark + 255]), 64'hC0000100);
         check_output("drain_tail", 64'(popped_q[mark + 256]), 64'h0BADF00D);
      end
      check_output("ovf_sticky", 64'(overflow), 64'd1);
      clr_overflow = 1'b1;
      @(posedge clk);
      #1 ovf_model = 1'b0;
      @(negedge clk);
      clr_overflow = 1'b0;
      repeat (2) @(negedge clk);
      check_output("ovf_cleared", 64'(overflow), 64'd0);

      $display("[TB] reset mid-word with ten words stored");
      start_frame();
      for (int i = 0; i < 10; i++) apply_stimulus(32'h7700_0000 + 32'(i), 1'b0, mw);
      send_partial(32'hFFFFFFFF, 13);
      check_output("pre_rst_level", 64'(fifo_level), 64'd10);
      rst_n = 1'b0;
      exp_q.delete();
      ovf_model = 1'b0;
      #2;
      check_reset_values("midrst");
      spi_cs_n = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      mark    = popped_q.size();
      m_ready = 1'b1;
      start_frame();
      apply_stimulus(32'h600DCAFE, 1'b0, mw);
      end_frame();
      check_output("post_rst_count", 64'(popped_q.size() - mark), 64'd1);
      if (popped_q.size() > mark) check_output("post_rst_word", 64'(popped_q[mark]), 64'h600DCAFE);
      check_output("final_ferr", 64'(ferr_cnt), 64'd1);
      m_ready = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_audio_rx.md
# spi_audio_rx

SPI slave front end for the audio path. It receives 32-bit PCM words from the host MCU over SPI mode 0 and synchronises them into the `clk` domain. Words are buffered in a FIFO and presented to the downstream I2S transmitter through a valid/ready stream. It replaces the stub buffer-fill logic in the DAC controller, which now pops samples from this block.

## Interface
- `WORD_W`, 32, bits per SPI word / audio sample.
- `FIFO_DEPTH`, 256, FIFO entries; power of two, ≥4.
- `SYNC_STAGES`, 2, flip-flop stages on each SPI input; ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `spi_sclk`  in  1  SPI clock, asynchronous to `clk`.
- `spi_cs_n`  in  1  chip select, active-low.
- `spi_mosi`  in  1  serial data, MSB first.
- `spi_miso`  out  1  serial status out (see Configuration).
- `m_data`  out  WORD_W  head-of-FIFO sample.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  consumer accepts; pop when `m_valid & m_ready`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.
- `clr_overflow`  in  1  single-cycle clear of `overflow`.
- `frame_err`  out  1  one-cycle pulse; CS deasserted mid-word.

## Operation
- SCLK, CS_N and MOSI each pass through `SYNC_STAGES` flops. Reset values: SCLK 0, CS_N 1, MOSI 0.
- Edges are detected on the synchronised SCLK against a 1-cycle-delayed copy.
- FSM states:
  - IDLE: synced CS_N high. Bit counter 0, shift register holds its value. Go to SHIFT on synced CS_N low.
  - SHIFT: on each synced SCLK rising edge, shift in MOSI at the LSB (MSB-first) and increment the bit counter.
  - When the counter reaches `WORD_W`: push the assembled word, reset the counter to 0, and stay in SHIFT. Back-to-back words need no CS toggle.
  - Synced CS_N high in SHIFT with counter ≠ 0: discard the partial word, pulse `frame_err`, go to IDLE.
  - Synced CS_N high in SHIFT with counter = 0: go to IDLE, no error.
- Push into a full FIFO: drop the word, set `overflow`. The stored contents are unaffected.
- `overflow` clears on `clr_overflow`. If a clear and a new overflow occur in the same cycle, the set wins.
- Push and pop in the same cycle when full: both take effect and the level is unchanged. Push and pop when empty: only the push takes effect.
- Pointers wrap modulo `FIFO_DEPTH`. The level is a full-width counter, so full (level = DEPTH) and empty (level = 0) are distinguishable.
- Reset values: `m_valid` 0, `m_data` 0, `fifo_level` 0, `overflow` 0, `frame_err` 0, `spi_miso` 0, FSM in IDLE.
- Reset mid-word or mid-stream discards all FIFO contents and any partial word.

## Timing
- `clk` must be ≥ 8× the maximum `spi_sclk` frequency, and each SCLK phase must last ≥ `SYNC_STAGES`+1 clk cycles.
- Push occurs 1 cycle after the final bit's SCLK rising edge is detected. With `SYNC_STAGES`=2 this is 4 clk cycles from the raw SCLK edge.
- FIFO is first-word-fall-through with a registered output: `m_valid` rises 1 cycle after a push into an empty FIFO.
- After a pop, the next word appears on `m_data` in the following cycle. Sustained throughput is 1 word per cycle.
- `fifo_level` updates in the cycle after the push or pop.
- `frame_err` asserts in the cycle after synced CS_N rises.

## Configuration
- `SPI_AUDIO_RX_STATUS_EN` defined:
  - At the start of each word (CS fall or word boundary), snapshot `{overflow, fifo_level}`, zero-extended to `WORD_W`.
  - Drive the snapshot MSB first on `spi_miso`, updating on each synced SCLK falling edge. The MSB is driven 1 cycle after synced CS_N falls.
  - `spi_miso` is 0 while CS_N is high.
- Undefined: `spi_miso` is tied to 0 and no snapshot logic is built.

## Structure
- The shared audio package holds `AUDIO_WORD_W` (32), `AUDIO_FIFO_DEPTH` (256), and the FSM state enum `spi_rx_state_t` {IDLE, SHIFT}.
- One sub-module, `sync_fifo`: single-clock, FWFT, parameterised width/depth, with level output. It is reusable by the I2S side.
- Synchroniser and edge-detect logic stay in the top level.

## Test plan
- Two back-to-back words `0xDEADBEEF`, `0x12345678` in one CS frame, `m_ready`=1 → both appear on `m_data` in order; `fifo_level` peaks at 1; no `frame_err`.
- CS raised after 17 bits, then full word `0xA5A5A5A5` → one `frame_err` pulse; only `0xA5A5A5A5` is popped.
- `m_ready`=0, 257 words sent → `fifo_level`=256, `overflow`=1; draining yields words 1..256 intact. `clr_overflow` → 0.
- Full FIFO with a simultaneous push and pop → level stays 256, the popped word is the oldest, and the new word lands at the tail.
- `rst_n` asserted mid-word with 10 words stored → all outputs return to reset values; the next full word is received correctly as the first entry.
- With `SPI_AUDIO_RX_STATUS_EN`, 5 words stored and not drained → the next word clocks out `spi_miso` pattern `0x00000005`.
